// File: rtl/siaminer_pkg.sv
// siaminer_pkg: constants and helpers for the siaminer hash datapath.
//   M04_W      - width of the m04 word that travels down the hash pipeline.
//   occ_width  - number of bits needed to count 0..depth valid stages.
//                The result is never less than 1.
package siaminer_pkg;

    localparam int M04_W = 64;

    // Width of a counter that ranges over 0..depth inclusive.
    function automatic int occ_width(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pipe_flush_stage.sv
// pipe_flush_stage: one valid+data register of the flushable delay line.
//   clk, rst           - clock; asynchronous active-high reset
//   en                 - load vld_in/data_in (low = hold)
//   flush              - clear the valid bit; overrides en
//   clear_data         - on flush, also zero the data register
//   vld_in, data_in    - word from the previous stage (or the line input)
//   vld_q, data_q      - registered word
module pipe_flush_stage #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic         clear_data,
    input  logic         vld_in,
    input  logic [W-1:0] data_in,
    output logic         vld_q,
    output logic [W-1:0] data_q
);

    logic         vld_reg;
    logic [W-1:0] data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_reg  <= 1'b0;
            data_reg <= '0;
        end else if (flush) begin
            vld_reg <= 1'b0;
            if (clear_data) begin
                data_reg <= '0;
            end
        end else if (en) begin
            // Data moves even when the valid bit is low.
            vld_reg  <= vld_in;
            data_reg <= data_in;
        end
    end

    assign vld_q  = vld_reg;
    assign data_q = data_reg;

endmodule

// File: rtl/pipe_flush_n.sv
// pipe_flush_n: DEPTH-stage valid/data delay line with flush, stall,
// occupancy tracking and a saturating count of inputs lost while stalled.
//   clk, rst         - clock; asynchronous active-high reset
//   found, valid     - flush requests (nonce found / new work); valid also
//                      clears the drop counter
//   stall            - hold every stage; a valid input is dropped and counted
//   vldIn, dataIn    - input word
//   vldOut, dataOut  - last stage, DEPTH cycles after presentation
//   occupancy        - number of stages holding a valid word
//   empty            - occupancy == 0
//   dropCnt          - inputs discarded while stalled, saturating
module pipe_flush_n
    import siaminer_pkg::*;
#(
    parameter int W          = M04_W,
    parameter int DEPTH      = 4,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int DROP_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         found,
    input  logic                         valid,
    input  logic                         stall,
    input  logic                         vldIn,
    input  logic [W-1:0]                 dataIn,
    output logic                         vldOut,
    output logic [W-1:0]                 dataOut,
    output logic [occ_width(DEPTH)-1:0]  occupancy,
    output logic                         empty,
    output logic [DROP_W-1:0]            dropCnt
);

    localparam int                OCC_W    = occ_width(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic flush;
    logic en;

    assign flush = found | valid;
    assign en    = ~stall;

    logic         stage_vld  [DEPTH];
    logic [W-1:0] stage_data [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic         vld_d;
            logic [W-1:0] data_d;

            if (gi == 0) begin : g_head
                assign vld_d  = vldIn;
                assign data_d = dataIn;
            end else begin : g_body
                assign vld_d  = stage_vld[gi-1];
                assign data_d = stage_data[gi-1];
            end

            pipe_flush_stage #(
                .W(W)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .en         (en),
                .flush      (flush),
                .clear_data (CLEAR_DATA),
                .vld_in     (vld_d),
                .data_in    (data_d),
                .vld_q      (stage_vld[gi]),
                .data_q     (stage_data[gi])
            );
        end
    endgenerate

    assign vldOut  = stage_vld[DEPTH-1];
    assign dataOut = stage_data[DEPTH-1];

    // Occupancy is kept as a register that tracks the popcount the stages
    // will hold after the same edge, so it is available without an adder
    // tree on the output path.
    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;

    always_comb begin
        occ_next = occ_reg;
        if (flush) begin
            occ_next = '0;
        end else if (!stall) begin
            // After a shift the last stage's word is gone; the new input
            // and stages 0..DEPTH-2 remain.
            occ_next = OCC_W'(vldIn);
            for (int i = 0; i < DEPTH - 1; i++) begin
                occ_next = occ_next + OCC_W'(stage_vld[i]);
            end
        end
    end

    // The valid clear wins over an increment; found alone leaves the
    // counter alone but still suppresses counting because a flush cycle
    // never drops.
    logic [DROP_W-1:0] drop_reg;
    logic [DROP_W-1:0] drop_next;

    always_comb begin
        drop_next = drop_reg;
        if (valid) begin
            drop_next = '0;
        end else if (!found && stall && vldIn && (drop_reg != DROP_MAX)) begin
            drop_next = drop_reg + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_reg  <= '0;
            drop_reg <= '0;
        end else begin
            occ_reg  <= occ_next;
            drop_reg <= drop_next;
        end
    end

    assign occupancy = occ_reg;
    assign empty     = (occ_reg == '0);
    assign dropCnt   = drop_reg;

endmodule

// File: tb/tb_pipe_flush_n.sv
module tb_pipe_flush_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        found;
    logic        valid;
    logic        stall;
    logic        vldIn;
    logic [63:0] dataIn;

    // Default instance: DEPTH=4, CLEAR_DATA=1, DROP_W=16
    logic        a_vld;
    logic [63:0] a_data;
    logic [2:0]  a_occ;
    logic        a_empty;
    logic [15:0] a_drop;

    // CLEAR_DATA=0 instance
    logic        n_vld;
    logic [63:0] n_data;
    logic [2:0]  n_occ;
    logic        n_empty;
    logic [15:0] n_drop;

    // DROP_W=4 instance
    logic        s_vld;
    logic [63:0] s_data;
    logic [2:0]  s_occ;
    logic        s_empty;
    logic [3:0]  s_drop;

    // DEPTH=1 instance
    logic        d_vld;
    logic [63:0] d_data;
    logic [0:0]  d_occ;
    logic        d_empty;
    logic [15:0] d_drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_flush_n dut (
        .clk(clk), .rst(rst), .found(found), .valid(valid), .stall(stall),
        .vldIn(vldIn), .dataIn(dataIn), .vldOut(a_vld), .dataOut(a_data),
        .occupancy(a_occ), .empty(a_empty), .dropCnt(a_drop)
    );

    pipe_flush_n #(.CLEAR_DATA(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .found(found), .valid(valid), .stall(stall),
        .vldIn(vldIn), .dataIn(dataIn), .vldOut(n_vld), .dataOut(n_data),
        .occupancy(n_occ), .empty(n_empty), .dropCnt(n_drop)
    );

    pipe_flush_n #(.DROP_W(4)) dut_sat (
        .clk(clk), .rst(rst), .found(found), .valid(valid), .stall(stall),
        .vldIn(vldIn), .dataIn(dataIn), .vldOut(s_vld), .dataOut(s_data),
        .occupancy(s_occ), .empty(s_empty), .dropCnt(s_drop)
    );

    pipe_flush_n #(.DEPTH(1)) dut_d1 (
        .clk(clk), .rst(rst), .found(found), .valid(valid), .stall(stall),
        .vldIn(vldIn), .dataIn(dataIn), .vldOut(d_vld), .dataOut(d_data),
        .occupancy(d_occ), .empty(d_empty), .dropCnt(d_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        found  = 1'b0;
        valid  = 1'b0;
        stall  = 1'b0;
        vldIn  = 1'b0;
        dataIn = 64'h0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        checks++;
        if (a_vld !== 1'b0 || a_data !== 64'h0 || a_occ !== 3'd0 || a_empty !== 1'b1 || a_drop !== 16'd0) begin
            errors++;
            $display("FAIL reset: vld=%b data=%h occ=%0d empty=%b drop=%0d, want 0/0/0/1/0", a_vld, a_data, a_occ, a_empty, a_drop);
        end
        rst = 1'b0;
        tick();
        $display("reset: vld=%b occ=%0d empty=%b drop=%0d", a_vld, a_occ, a_empty, a_drop);
    endtask

    task automatic test_latency();
        logic [63:0] w = 64'h0123456789ABCDEF;
        vldIn  = 1'b1;
        dataIn = w;
        for (int c = 1; c <= 5; c++) begin
            tick();
            vldIn  = 1'b0;
            dataIn = 64'h0;
            checks++;
            if (a_occ !== ((c <= 4) ? 3'd1 : 3'd0)) begin
                errors++;
                $display("FAIL latency_occ cycle %0d: got %0d want %0d", c, a_occ, (c <= 4) ? 1 : 0);
            end
            checks++;
            if (a_vld !== (c == 4)) begin
                errors++;
                $display("FAIL latency_vld cycle %0d: got %b want %b", c, a_vld, (c == 4));
            end
            if (c == 4) begin
                checks++;
                if (a_data !== w) begin
                    errors++;
                    $display("FAIL latency_data: got %h want %h", a_data, w);
                end
            end
            $display("latency cycle %0d: vld=%b data=%h occ=%0d", c, a_vld, a_data, a_occ);
        end
        checks++;
        if (a_empty !== 1'b1) begin
            errors++;
            $display("FAIL latency_empty: got %b want 1", a_empty);
        end
    endtask

    task automatic test_stall();
        logic [63:0] words [4];
        words[0] = 64'hA000_0000_0000_0001;
        words[1] = 64'hA000_0000_0000_0002;
        words[2] = 64'hA000_0000_0000_0003;
        words[3] = 64'hA000_0000_0000_0004;
        for (int k = 0; k < 4; k++) begin
            vldIn  = 1'b1;
            dataIn = words[k];
            tick();
            $display("stall stream word %0d: %h occ=%0d", k, words[k], a_occ);
        end
        stall  = 1'b1;
        vldIn  = 1'b1;
        dataIn = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (a_vld !== 1'b1 || a_data !== words[0] || a_occ !== 3'd4) begin
                errors++;
                $display("FAIL stall_hold %0d: vld=%b data=%h occ=%0d want 1/%h/4", k, a_vld, a_data, a_occ, words[0]);
            end
        end
        checks++;
        if (a_drop !== 16'd3) begin
            errors++;
            $display("FAIL stall_drop: got %0d want 3", a_drop);
        end
        idle();
        for (int k = 1; k < 4; k++) begin
            tick();
            checks++;
            if (a_vld !== 1'b1 || a_data !== words[k]) begin
                errors++;
                $display("FAIL stall_release %0d: vld=%b data=%h want 1/%h", k, a_vld, a_data, words[k]);
            end
            $display("stall release word %0d: %h", k, a_data);
        end
        tick();
        checks++;
        if (a_vld !== 1'b0 || a_occ !== 3'd0) begin
            errors++;
            $display("FAIL stall_drain: vld=%b occ=%0d want 0/0", a_vld, a_occ);
        end
    endtask

    task automatic fill(input logic [63:0] base);
        for (int k = 0; k < 4; k++) begin
            vldIn  = 1'b1;
            dataIn = base + 64'(k);
            tick();
        end
        idle();
    endtask

    task automatic test_flush_priority();
        fill(64'hB000_0000_0000_0010);
        found  = 1'b1;
        stall  = 1'b1;
        vldIn  = 1'b1;
        dataIn = 64'h1111_2222_3333_4444;
        tick();
        idle();
        checks++;
        if (a_occ !== 3'd0 || a_vld !== 1'b0 || a_data !== 64'h0 || a_empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_prio: occ=%0d vld=%b data=%h empty=%b want 0/0/0/1", a_occ, a_vld, a_data, a_empty);
        end
        checks++;
        if (a_drop !== 16'd3) begin
            errors++;
            $display("FAIL flush_prio_drop: got %0d want 3", a_drop);
        end
        $display("flush priority: occ=%0d vld=%b drop=%0d", a_occ, a_vld, a_drop);
    endtask

    task automatic test_no_clear_data();
        fill(64'hC000_0000_0000_0020);
        checks++;
        if (n_vld !== 1'b1 || n_data !== 64'hC000_0000_0000_0020) begin
            errors++;
            $display("FAIL nc_full: vld=%b data=%h want 1/c000000000000020", n_vld, n_data);
        end
        valid = 1'b1;
        tick();
        idle();
        checks++;
        if (n_vld !== 1'b0 || n_occ !== 3'd0 || n_data !== 64'hC000_0000_0000_0020 || n_drop !== 16'd0) begin
            errors++;
            $display("FAIL nc_flush: vld=%b occ=%0d data=%h drop=%0d want 0/0/c000000000000020/0", n_vld, n_occ, n_data, n_drop);
        end
        checks++;
        if (a_drop !== 16'd0 || a_data !== 64'h0) begin
            errors++;
            $display("FAIL valid_clear: drop=%0d data=%h want 0/0", a_drop, a_data);
        end
        $display("no-clear flush: vld=%b occ=%0d data=%h drop=%0d", n_vld, n_occ, n_data, n_drop);
    endtask

    task automatic test_saturation_async_reset();
        fill(64'hD000_0000_0000_0030);
        stall  = 1'b1;
        vldIn  = 1'b1;
        dataIn = 64'h5555_5555_5555_5555;
        for (int k = 0; k < 20; k++) begin
            tick();
        end
        checks++;
        if (s_drop !== 4'd15) begin
            errors++;
            $display("FAIL sat_drop: got %0d want 15", s_drop);
        end
        checks++;
        if (a_drop !== 16'd20 || a_occ !== 3'd4) begin
            errors++;
            $display("FAIL wide_drop: drop=%0d occ=%0d want 20/4", a_drop, a_occ);
        end
        $display("saturation: drop4=%0d drop16=%0d", s_drop, a_drop);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (a_vld !== 1'b0 || a_data !== 64'h0 || a_occ !== 3'd0 || a_empty !== 1'b1 || a_drop !== 16'd0 || s_drop !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: vld=%b data=%h occ=%0d empty=%b drop=%0d sdrop=%0d", a_vld, a_data, a_occ, a_empty, a_drop, s_drop);
        end
        idle();
        tick();
        rst = 1'b0;
        tick();
        $display("async reset: vld=%b occ=%0d drop=%0d", a_vld, a_occ, a_drop);
    endtask

    task automatic test_equivalence();
        logic        mv = 1'b0;
        logic [63:0] md = 64'h0;
        int          bad = 0;
        for (int c = 0; c < 1000; c++) begin
            found  = ($urandom_range(0, 7) == 0);
            valid  = ($urandom_range(0, 7) == 0);
            vldIn  = $urandom_range(0, 1) == 1;
            dataIn = {$urandom, $urandom};
            stall  = 1'b0;
            tick();
            if (found || valid) begin
                mv = 1'b0;
                md = 64'h0;
            end else begin
                mv = vldIn;
                md = dataIn;
            end
            checks++;
            if (d_vld !== mv || d_data !== md) begin
                errors++;
                bad++;
                $display("FAIL equiv cycle %0d: vld=%b data=%h want %b/%h", c, d_vld, d_data, mv, md);
            end
        end
        idle();
        $display("equivalence: 1000 cycles, %0d differences", bad);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_latency();
        test_stall();
        test_flush_priority();
        test_no_clear_data();
        test_saturation_async_reset();
        test_equivalence();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_flush_n.md
Name: pipe_flush_n

Overview:
Parametrised multi-stage valid/data delay line for the siaminer hash datapath, successor to the single-stage flushable register.
- Carries a W-bit word (default: the 64-bit m04 word) through DEPTH register stages.
- Flushes every stage when a nonce is found or new work arrives.
- Adds stall (hold), occupancy tracking, an empty flag and a saturating drop counter for inputs lost while stalled.

Parameters:
W, 64, data width in bits (>=1)
DEPTH, 4, number of register stages = latency in cycles (>=1)
CLEAR_DATA, 1, 1: flush also zeroes data; 0: flush clears valids only (data regs keep contents)
DROP_W, 16, width of drop counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
found  in  1  nonce found; flush request
valid  in  1  new work arrived; flush request, also clears drop counter
stall  in  1  hold all stages
vldIn  in  1  input word valid
dataIn  in  W  input word
vldOut  out  1  valid of last stage
dataOut  out  W  data of last stage
occupancy  out  $clog2(DEPTH+1)  number of stages holding valid data
empty  out  1  occupancy == 0
dropCnt  out  DROP_W  inputs discarded while stalled, saturating

Behaviour:
- Reset. Clock and reset are fixed: one clock `clk`; `rst` is asynchronous and active-high.
  - rst=1 clears every stage vld and data to 0.
  - vldOut=0, dataOut=0, occupancy=0, empty=1, dropCnt=0.
  - Reset mid-operation discards all in-flight words immediately; no output pulse.
- Flush. flush = found | valid.
  - Next cycle all stage valids = 0.
  - If CLEAR_DATA=1, all stage data = 0.
  - Flush has priority over stall.
  - vldIn presented in a flush cycle is discarded and is NOT counted as a drop.
- Normal advance (flush=0, stall=0):
  - stage0 <= {vldIn, dataIn}; stage[i] <= stage[i-1] for i = 1..DEPTH-1.
  - Data shifts even when vld=0, matching the flushable-register behaviour.
  - Latency: a word accepted at edge t appears on vldOut/dataOut after edge t+DEPTH-1, i.e. DEPTH cycles after presentation.
- Stall (flush=0, stall=1):
  - All stages hold; outputs are stable.
  - vldIn=1 is not accepted. dropCnt increments by 1, saturating at 2^DROP_W-1.
- No backpressure toward the output: vldOut is a one-cycle-per-word pulse stream, and the consumer must accept every word.
- Occupancy:
  - Registered; equals the popcount of stage valids after the same edge.
  - Range 0..DEPTH, never wraps.
  - Goes to 0 the cycle after a flush.
  - empty is combinational from occupancy.
- dropCnt:
  - valid=1 clears it to 0. The clear takes priority over an increment in the same cycle (stall is irrelevant during flush anyway).
  - found alone does not clear it.
- Simultaneous found & valid: a single flush plus dropCnt clear.
- DEPTH=1, stall=0, CLEAR_DATA=1 must be cycle-identical to the existing single-stage pipe.

Decomposition:
- Package siaminer_pkg holds:
  - the M04_W=64 default width constant;
  - a helper constant/function for the occupancy width ($clog2(DEPTH+1) with a minimum of 1).
- One sub-module, pipe_flush_stage:
  - one vld+data register with inputs en (=!stall), flush, clear_data;
  - instantiated DEPTH times in a generate loop.
- Occupancy counter and drop counter live in the top module.

Test Plan:
1. Reset and single-word latency. DEPTH=4, W=64: rst pulse, then vldIn=1 with data 0x0123456789ABCDEF for 1 cycle -> vldOut=1 with that data exactly 4 cycles later; occupancy steps 1,1,1,1 then 0; empty=1 afterwards.
2. Stall holds and drops. Stream 4 consecutive words, assert stall for 3 cycles with vldIn=1 -> outputs frozen, occupancy stays 4, dropCnt=3. Release stall -> the 4 words exit in order, unchanged.
3. Flush priority over stall. Pipe full, pulse found together with stall=1 and vldIn=1 -> next cycle occupancy=0, vldOut=0, dataOut=0 (CLEAR_DATA=1), dropCnt unchanged.
4. CLEAR_DATA=0. Full pipe, valid pulse -> vldOut=0 and occupancy=0, dataOut retains its last value, dropCnt=0.
5. Saturation and async reset. DROP_W=4, stall with vldIn=1 for 20 cycles -> dropCnt=15. Then assert rst asynchronously between edges -> all outputs go to reset values before the next edge.
6. Equivalence. DEPTH=1 with random found/valid/vldIn/data over 1000 cycles -> matches a single-stage flushable-register model cycle by cycle.
